// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the 64 x 16 data memory.
// Optional out-of-range guard enabled by defining DMEM_ADDR_CHK_EN.
module dmem_arbiter #(
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_wea,
    input  logic [DW-1:0] mem_dout,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

`ifdef DMEM_ADDR_CHK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    state_t        state_q, state_d;
    logic          last_b_q, last_b_d;   // 1 when port B holds the most recent grant
    logic          win_b_q, win_b_d;
    logic          we_q, we_d;
    logic          oor_q, oor_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          mem_wea_q, mem_wea_d;
    logic          a_ack_q, a_ack_d;
    logic          b_ack_q, b_ack_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;

    logic          sel_b;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_oor;
    logic [DW-1:0] rd_value;

    // Tie goes to whichever port did not win last time.
    assign sel_b     = b_req & (~a_req | ~last_b_q);
    assign sel_we    = sel_b ? b_we    : a_we;
    assign sel_addr  = sel_b ? b_addr  : a_addr;
    assign sel_wdata = sel_b ? b_wdata : a_wdata;
    assign sel_oor   = CHK_EN & ({1'b0, sel_addr} >= DEPTH_W);
    assign rd_value  = oor_q ? '0 : mem_dout;

    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        win_b_d    = win_b_q;
        we_d       = we_q;
        oor_d      = oor_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_wea_d  = 1'b0;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (a_req | b_req) begin
                    win_b_d    = sel_b;
                    we_d       = sel_we;
                    oor_d      = sel_oor;
                    mem_addr_d = sel_addr;
                    mem_din_d  = sel_wdata;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                // Address and data have settled for a full cycle; write strobe follows.
                mem_wea_d = we_q & ~oor_q;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (!we_q) begin
                    if (win_b_q) begin
                        b_rdata_d = rd_value;
                    end else begin
                        a_rdata_d = rd_value;
                    end
                end
                a_ack_d = ~win_b_q;
                b_ack_d = win_b_q;
                err_d   = oor_q;
                state_d = RESP;
            end
            RESP: begin
                last_b_d = win_b_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;
            win_b_q    <= 1'b0;
            we_q       <= 1'b0;
            oor_q      <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_wea_q  <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            win_b_q    <= win_b_d;
            we_q       <= we_d;
            oor_q      <= oor_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_wea_q  <= mem_wea_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign mem_wea  = mem_wea_q;
    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a 64-word behavioural memory behind the arbiter,
// hand-computed expectations per cycle (cycle 0 = IDLE cycle that samples the request).
module tb_dmem_arbiter;

`ifdef DMEM_ADDR_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ack, b_ack;
    logic [15:0] a_rdata, b_rdata;
    logic [15:0] mem_addr, mem_din, mem_dout;
    logic        mem_wea, busy, err;

    logic [15:0] mem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(16), .DW(16), .DEPTH(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_ack    (a_ack),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_ack    (b_ack),
        .b_rdata  (b_rdata),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_wea  (mem_wea),
        .mem_dout (mem_dout),
        .busy     (busy),
        .err      (err)
    );

    // Level-sensitive read, write on the clock while wea is high.
    assign mem_dout = mem[mem_addr[5:0]];
    always @(posedge clk) begin
        if (mem_wea) mem[mem_addr[5:0]] <= mem_din;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {28'd0, a_ack, b_ack, mem_wea, busy}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_addr"}, {16'd0, mem_addr}, 32'd0);
        check({tag, "_din"}, {16'd0, mem_din}, 32'd0);
        check({tag, "_rdata"}, {a_rdata, b_rdata}, 32'd0);
    endtask

    // One isolated transaction on one port; inputs are scrambled after the grant
    // to confirm they are ignored for the transaction in flight.
    task automatic run_txn(input bit pb, input bit we, input logic [15:0] addr,
                           input logic [15:0] data, input logic [15:0] exp_rd,
                           input bit exp_err);
        logic [15:0] rd;
        @(negedge clk);
        if (pb) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = data; end
        else    begin a_req = 1; a_we = we; a_addr = addr; a_wdata = data; end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            rd = pb ? b_rdata : a_rdata;
            check($sformatf("c%0d_busy", c), {31'd0, busy}, {31'd0, (c != 4)});
            check($sformatf("c%0d_wea", c), {31'd0, mem_wea}, {31'd0, (c == 2) && we && !exp_err});
            check($sformatf("c%0d_ack", c), {30'd0, a_ack, b_ack},
                  {30'd0, (c == 3) && !pb, (c == 3) && pb});
            check($sformatf("c%0d_err", c), {31'd0, err}, {31'd0, (c == 3) && exp_err});
            if (c <= 3) begin
                check($sformatf("c%0d_addr", c), {16'd0, mem_addr}, {16'd0, addr});
                check($sformatf("c%0d_din", c), {16'd0, mem_din}, {16'd0, data});
            end
            if (c == 1) begin
                if (pb) begin b_we = ~we; b_addr = addr ^ 16'h00F0; b_wdata = ~data; end
                else    begin a_we = ~we; a_addr = addr ^ 16'h00F0; a_wdata = ~data; end
            end
            if (c == 3) begin
                if (!we) check("c3_rdata", {16'd0, rd}, {16'd0, exp_rd});
                a_req = 0;
                b_req = 0;
            end
        end
        $display("txn port=%s we=%0d addr=%h data=%h rdata=%h err_exp=%0d",
                 pb ? "B" : "A", we, addr, data, rd, exp_err);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0100 + 16'(i);
        rst = 1; a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
        do_reset();
        $display("reset done");

        // A write then read back
        run_txn(1'b0, 1'b1, 16'd5, 16'hBEEF, 16'h0000, 1'b0);
        run_txn(1'b0, 1'b0, 16'd5, 16'h0000, 16'hBEEF, 1'b0);

        // A read of 0 in flight, B write 63 arrives a cycle later
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 16'd0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin b_req = 1; b_we = 1; b_addr = 16'd63; b_wdata = 16'h1234; end
            check($sformatf("ov%0d_ack", c), {30'd0, a_ack, b_ack}, {30'd0, c == 3, c == 7});
            check($sformatf("ov%0d_wea", c), {31'd0, mem_wea}, {31'd0, c == 6});
            if (c == 3) begin
                check("ov_a_rdata", {16'd0, a_rdata}, 32'h0000_0100);
                a_req = 0;
            end
            if (c == 7) b_req = 0;
        end
        $display("overlap A read 0 then B write 63 done");
        run_txn(1'b1, 1'b0, 16'd63, 16'h0000, 16'h1234, 1'b0);
        check("a_rdata_kept", {16'd0, a_rdata}, 32'h0000_0100);

        // Both held from reset: grants alternate A, B, A, B
        do_reset();
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 16'd10;
        b_req = 1; b_we = 0; b_addr = 16'd20;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            check($sformatf("rr%0d_ack", c), {30'd0, a_ack, b_ack},
                  {30'd0, (c % 8) == 3, (c % 8) == 7});
            if ((c % 8) == 3) check($sformatf("rr%0d_ardata", c), {16'd0, a_rdata}, 32'h0000_010A);
            if ((c % 8) == 7) check($sformatf("rr%0d_brdata", c), {16'd0, b_rdata}, 32'h0000_0114);
            if (c == 15) begin a_req = 0; b_req = 0; end
        end
        $display("round-robin alternation done");

        // Reset during ACCESS of an A write, request held
        do_reset();
        @(negedge clk);
        a_req = 1; a_we = 1; a_addr = 16'd7; a_wdata = 16'h7777;
        @(negedge clk);
        @(negedge clk);
        check("rs_wea_access", {31'd0, mem_wea}, 32'd1);
        rst = 1;
        @(negedge clk);
        check_all_zero("rs_abort");
        rst = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("rs%0d_ack", c), {30'd0, a_ack, b_ack}, {30'd0, c == 3, 1'b0});
            if (c == 3) a_req = 0;
        end
        check("rs_mem7", {16'd0, mem[7]}, 32'h0000_7777);
        $display("reset mid-write then restart done");

        // Out-of-range accesses (guarded only when the check is built in)
        run_txn(1'b0, 1'b1, 16'd64, 16'hFFFF, 16'h0000, CHK);
        run_txn(1'b0, 1'b0, 16'd100, 16'h0000, CHK ? 16'h0000 : 16'h0124, CHK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
